// File: rtl/weight_read_sequencer.sv
// Weight-memory read sequencer: pairs each accepted input sample with the weight
// fetched at its address, one pair per beat, then drains and pulses done.
module weight_read_sequencer #(
    parameter int numWeight    = 784,
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   in_valid,
    input  logic [dataWidth-1:0]   in_data,
    output logic                   in_ready,
    output logic                   ren,
    output logic [addressWidth:0]  raddr,
    input  logic [dataWidth-1:0]   wout,
    output logic                   mul_valid,
    output logic [dataWidth-1:0]   mul_x,
    output logic [dataWidth-1:0]   mul_w,
    output logic                   mul_last,
    output logic                   busy,
    output logic                   done
);

    localparam logic [addressWidth:0] C_LAST = (addressWidth+1)'(numWeight - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [addressWidth:0] r_cnt;
    logic                  r_mul_valid;
    logic                  r_mul_last;
    logic [dataWidth-1:0]  r_mul_x;
    logic                  w_beat;
    logic                  w_at_last;

    assign w_beat    = (r_state == S_RUN) && in_valid;
    assign w_at_last = (r_cnt == C_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        ren      = 1'b0;
        raddr    = '0;
        busy     = 1'b1;
        done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_next = S_RUN;
            end
            S_RUN: begin
                in_ready = 1'b1;
                ren      = in_valid;
                raddr    = r_cnt;
                if (w_beat && w_at_last) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // The weight arrives one cycle after ren, so the sample is delayed to meet it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_mul_valid <= 1'b0;
            r_mul_last  <= 1'b0;
            r_mul_x     <= '0;
        end else begin
            r_mul_valid <= w_beat;
            r_mul_last  <= w_beat && w_at_last;
            if (w_beat) begin
                r_mul_x <= in_data;
            end
            if ((r_state == S_IDLE) && start) begin
                r_cnt <= '0;
            end else if (w_beat && !w_at_last) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign mul_valid = r_mul_valid;
    assign mul_last  = r_mul_last;
    assign mul_x     = r_mul_x;
    assign mul_w     = wout;

endmodule

// File: tb/tb_weight_read_sequencer.sv
// Directed bench for weight_read_sequencer: a numWeight=4 instance for the main
// scenarios and a numWeight=1 instance for the single-weight corner.
module tb_weight_read_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          total = 0;
    int          bad   = 0;

    logic        st4 = 1'b0, iv4 = 1'b0;
    logic [15:0] id4 = '0;
    logic        in_ready4, ren4, mul_valid4, mul_last4, busy4, done4;
    logic [10:0] raddr4;
    logic [15:0] wout4 = '0, mul_x4, mul_w4;

    logic        st1 = 1'b0, iv1 = 1'b0;
    logic [15:0] id1 = '0;
    logic        in_ready1, ren1, mul_valid1, mul_last1, busy1, done1;
    logic [10:0] raddr1;
    logic [15:0] wout1 = '0, mul_x1, mul_w1;

    always #5 clk = ~clk;

    weight_read_sequencer #(.numWeight(4), .addressWidth(10), .dataWidth(16)) u4 (
        .clk(clk), .rst(rst), .start(st4), .in_valid(iv4), .in_data(id4),
        .in_ready(in_ready4), .ren(ren4), .raddr(raddr4), .wout(wout4),
        .mul_valid(mul_valid4), .mul_x(mul_x4), .mul_w(mul_w4), .mul_last(mul_last4),
        .busy(busy4), .done(done4));

    weight_read_sequencer #(.numWeight(1), .addressWidth(10), .dataWidth(16)) u1 (
        .clk(clk), .rst(rst), .start(st1), .in_valid(iv1), .in_data(id1),
        .in_ready(in_ready1), .ren(ren1), .raddr(raddr1), .wout(wout1),
        .mul_valid(mul_valid1), .mul_x(mul_x1), .mul_w(mul_w1), .mul_last(mul_last1),
        .busy(busy1), .done(done1));

    function automatic logic [15:0] wmem4(input logic [10:0] a);
        return 16'hA000 + {5'd0, a};
    endfunction

    function automatic logic [15:0] wmem1(input logic [10:0] a);
        return 16'hB000 + {5'd0, a};
    endfunction

    // Synchronous-read weight memories
    always @(posedge clk) if (ren4) wout4 <= wmem4(raddr4);
    always @(posedge clk) if (ren1) wout1 <= wmem1(raddr1);

    task automatic check_all_zero4(input string tag);
        total++;
        if ({in_ready4, ren4, raddr4, mul_valid4, mul_last4, mul_x4, busy4, done4} !== '0) begin
            bad++;
            $display("FAIL %s: ir=%b ren=%b raddr=%0d mv=%b ml=%b mx=%h busy=%b done=%b, all required 0",
                     tag, in_ready4, ren4, raddr4, mul_valid4, mul_last4, mul_x4, busy4, done4);
        end
    endtask

    task automatic wait_done4(input string tag);
        int seen = 0;
        for (int c = 0; c < 6 && seen == 0; c++) begin
            @(posedge clk); #1;
            if (done4) seen = 1;
        end
        total++;
        if (seen != 1) begin
            bad++;
            $display("FAIL %s: done not seen within 6 cycles, required done=1", tag);
        end
        @(posedge clk); #1;
        total++;
        if (done4 !== 1'b0 || busy4 !== 1'b0) begin
            bad++;
            $display("FAIL %s_idle: done=%b busy=%b required 0 0", tag, done4, busy4);
        end
    endtask

    task automatic start4();
        st4 = 1'b1;
        @(posedge clk); #1;
        st4 = 1'b0;
    endtask

    task automatic beat4(input logic [10:0] a, input logic [15:0] d, input string tag);
        iv4 = 1'b1; id4 = d; #1;
        total++;
        if (ren4 !== 1'b1 || raddr4 !== a || in_ready4 !== 1'b1) begin
            bad++;
            $display("FAIL %s_addr: ren=%b ir=%b raddr=%0d required 1 1 %0d", tag, ren4, in_ready4, raddr4, a);
        end
        @(posedge clk); #1;
        total++;
        if (mul_valid4 !== 1'b1 || mul_x4 !== d || mul_w4 !== wmem4(a)) begin
            bad++;
            $display("FAIL %s_pair: mv=%b x=%h w=%h required 1 %h %h", tag, mul_valid4, mul_x4, mul_w4, d, wmem4(a));
        end
        iv4 = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        check_all_zero4("reset");
        total++;
        if ({ren1, raddr1, mul_valid1, busy1, done1} !== '0) begin
            bad++;
            $display("FAIL reset_nw1: ren=%b raddr=%0d mv=%b busy=%b done=%b required 0",
                     ren1, raddr1, mul_valid1, busy1, done1);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_idle_valid();
        iv4 = 1'b1; id4 = 16'h5555;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if (ren4 !== 1'b0 || in_ready4 !== 1'b0) begin
                bad++;
                $display("FAIL idle_valid: ren=%b ir=%b required 0 0", ren4, in_ready4);
            end
            @(posedge clk); #1;
            total++;
            if (mul_valid4 !== 1'b0 || busy4 !== 1'b0) begin
                bad++;
                $display("FAIL idle_mv: mv=%b busy=%b required 0 0", mul_valid4, busy4);
            end
        end
        iv4 = 1'b0;
    endtask

    task automatic test_basic();
        start4();
        for (int i = 0; i < 4; i++) begin
            iv4 = 1'b1; id4 = 16'(i + 1); #1;
            total++;
            if (ren4 !== 1'b1 || raddr4 !== 11'(i)) begin
                bad++;
                $display("FAIL basic_addr%0d: ren=%b raddr=%0d required 1 %0d", i, ren4, raddr4, i);
            end
            @(posedge clk); #1;
            total++;
            if (mul_valid4 !== 1'b1 || mul_x4 !== 16'(i + 1) || mul_w4 !== wmem4(11'(i)) ||
                mul_last4 !== (i == 3)) begin
                bad++;
                $display("FAIL basic_pair%0d: mv=%b x=%h w=%h last=%b required 1 %h %h %b",
                         i, mul_valid4, mul_x4, mul_w4, mul_last4, 16'(i + 1), wmem4(11'(i)), i == 3);
            end
        end
        // in_valid stays high through DRAIN and must be ignored
        total++;
        if (in_ready4 !== 1'b0 || ren4 !== 1'b0 || busy4 !== 1'b1 || done4 !== 1'b0) begin
            bad++;
            $display("FAIL basic_drain: ir=%b ren=%b busy=%b done=%b required 0 0 1 0",
                     in_ready4, ren4, busy4, done4);
        end
        @(posedge clk); #1;
        total++;
        if (done4 !== 1'b1 || mul_valid4 !== 1'b0 || ren4 !== 1'b0) begin
            bad++;
            $display("FAIL basic_done: done=%b mv=%b ren=%b required 1 0 0", done4, mul_valid4, ren4);
        end
        iv4 = 1'b0;
        @(posedge clk); #1;
        total++;
        if (done4 !== 1'b0 || busy4 !== 1'b0) begin
            bad++;
            $display("FAIL basic_idle: done=%b busy=%b required 0 0", done4, busy4);
        end
    endtask

    task automatic test_stall();
        int          pat[7] = '{1, 0, 0, 1, 1, 0, 1};
        logic [10:0] exp_a  = '0;
        int          pulses = 0;
        start4();
        for (int j = 0; j < 7; j++) begin
            iv4 = pat[j][0]; id4 = 16'h0010 + {5'd0, exp_a}; #1;
            total++;
            if (ren4 !== pat[j][0] || raddr4 !== exp_a) begin
                bad++;
                $display("FAIL stall_addr%0d: ren=%b raddr=%0d required %b %0d", j, ren4, raddr4, pat[j][0], exp_a);
            end
            @(posedge clk); #1;
            pulses += int'(mul_valid4);
            total++;
            if (mul_valid4 !== pat[j][0]) begin
                bad++;
                $display("FAIL stall_mv%0d: mv=%b required %b", j, mul_valid4, pat[j][0]);
            end
            if (pat[j] == 1) begin
                total++;
                if (mul_x4 !== 16'h0010 + {5'd0, exp_a} || mul_w4 !== wmem4(exp_a)) begin
                    bad++;
                    $display("FAIL stall_pair%0d: x=%h w=%h required %h %h",
                             j, mul_x4, mul_w4, 16'h0010 + {5'd0, exp_a}, wmem4(exp_a));
                end
                exp_a = exp_a + 11'd1;
            end
        end
        iv4 = 1'b0;
        total++;
        if (pulses != 4 || mul_last4 !== 1'b1) begin
            bad++;
            $display("FAIL stall_count: pulses=%0d last=%b required 4 1", pulses, mul_last4);
        end
        wait_done4("stall_done");
    endtask

    task automatic test_start_ignored();
        int dones = 0;
        start4();
        beat4(11'd0, 16'h0100, "sig_b0");
        beat4(11'd1, 16'h0101, "sig_b1");
        st4 = 1'b1; iv4 = 1'b0;
        @(posedge clk); #1;
        st4 = 1'b0;
        total++;
        if (raddr4 !== 11'd2 || busy4 !== 1'b1 || mul_valid4 !== 1'b0) begin
            bad++;
            $display("FAIL start_in_run: raddr=%0d busy=%b mv=%b required 2 1 0", raddr4, busy4, mul_valid4);
        end
        beat4(11'd2, 16'h0102, "sig_b2");
        beat4(11'd3, 16'h0103, "sig_b3");
        @(posedge clk); #1;
        dones += int'(done4);
        st4 = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            st4 = 1'b0;
            dones += int'(done4);
            total++;
            if (busy4 !== 1'b0) begin
                bad++;
                $display("FAIL start_in_done%0d: busy=%b required 0", c, busy4);
            end
        end
        total++;
        if (dones != 1) begin
            bad++;
            $display("FAIL start_single_done: done pulses=%0d required 1", dones);
        end
    endtask

    task automatic test_reset_mid();
        start4();
        beat4(11'd0, 16'h0020, "rm_b0");
        beat4(11'd1, 16'h0021, "rm_b1");
        iv4 = 1'b1;
        #2 rst = 1'b1;
        #1;
        check_all_zero4("reset_mid_async");
        @(posedge clk); #1;
        rst = 1'b0; iv4 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            total++;
            if (done4 !== 1'b0 || busy4 !== 1'b0) begin
                bad++;
                $display("FAIL reset_mid_nodone%0d: done=%b busy=%b required 0 0", c, done4, busy4);
            end
        end
        start4();
        beat4(11'd0, 16'h0030, "rm_restart0");
        beat4(11'd1, 16'h0031, "rm_restart1");
        beat4(11'd2, 16'h0032, "rm_restart2");
        beat4(11'd3, 16'h0033, "rm_restart3");
        wait_done4("rm_done");
    endtask

    task automatic test_nw1();
        st1 = 1'b1;
        @(posedge clk); #1;
        st1 = 1'b0; iv1 = 1'b1; id1 = 16'h0007; #1;
        total++;
        if (ren1 !== 1'b1 || raddr1 !== 11'd0 || in_ready1 !== 1'b1) begin
            bad++;
            $display("FAIL nw1_addr: ren=%b ir=%b raddr=%0d required 1 1 0", ren1, in_ready1, raddr1);
        end
        @(posedge clk); #1;
        total++;
        if (mul_valid1 !== 1'b1 || mul_last1 !== 1'b1 || mul_x1 !== 16'h0007 || mul_w1 !== 16'hB000 ||
            in_ready1 !== 1'b0 || ren1 !== 1'b0 || busy1 !== 1'b1 || done1 !== 1'b0) begin
            bad++;
            $display("FAIL nw1_drain: mv=%b ml=%b x=%h w=%h ir=%b ren=%b busy=%b done=%b required 1 1 0007 b000 0 0 1 0",
                     mul_valid1, mul_last1, mul_x1, mul_w1, in_ready1, ren1, busy1, done1);
        end
        iv1 = 1'b0;
        @(posedge clk); #1;
        total++;
        if (done1 !== 1'b1 || mul_valid1 !== 1'b0) begin
            bad++;
            $display("FAIL nw1_done: done=%b mv=%b required 1 0", done1, mul_valid1);
        end
        @(posedge clk); #1;
        total++;
        if (done1 !== 1'b0 || busy1 !== 1'b0) begin
            bad++;
            $display("FAIL nw1_idle: done=%b busy=%b required 0 0", done1, busy1);
        end
    endtask

    initial begin
        test_reset();
        test_idle_valid();
        test_basic();
        test_stall();
        test_start_ignored();
        test_reset_mid();
        test_nw1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
